// File: rtl/lram_pkg.sv
// Shared types and defaults for the LRAM request sequencer.
// State enum, default geometry and credit-counter width.
package lram_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } lram_state_e;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_RD_LAT = 1;
    localparam int DEF_DEPTH  = 4;
    localparam int CNT_W      = $clog2(DEF_DEPTH + 1);

endpackage

// File: rtl/lram_resp_fifo.sv
// First-word-fall-through response FIFO with occupancy count.
// Ports: clock, reset_n, push/wdata in, pop in, rdata/valid/count out.
module lram_resp_fifo
    import lram_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              valid,
    output logic [CNT_W-1:0]  count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic              do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    // Head is zeroed while empty so stale entries never leak out.
    assign rdata  = valid ? mem[rp] : '0;

    always_ff @(posedge clock) begin
        if (push) mem[wp] <= wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            assert (!(push && count == CNT_W'(DEPTH)));
            if (push)   wp <= nxt(wp);
            if (do_pop) rp <= nxt(rp);
            if (push && !do_pop)      count <= count + CNT_W'(1);
            else if (!push && do_pop) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/lram_req_ctrl.sv
// LRAM request sequencer: registered LRAM pins, read-latency tracking,
// credit-guarded response FIFO. Optional init sweep: LRAM_REQ_CTRL_SWEEP_EN.
// Ports: clock, reset_n; req_* (valid/ready in); resp_* (valid/ready out);
// lram_addr/lram_data/lram_wen to LRAM, lram_y from LRAM.
module lram_req_ctrl
    import lram_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                RD_LAT   = DEF_RD_LAT,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] lram_addr,
    output logic [DATA_W-1:0] lram_data,
    output logic              lram_wen,
    input  logic [DATA_W-1:0] lram_y
);

    localparam int            CW  = $clog2(DEPTH + 1);
    localparam int            SRW = RD_LAT + 1;
    localparam logic [CW:0]   CAP = (CW + 1)'(DEPTH);

    lram_state_e    state;
    logic           live;
    logic [SRW-1:0] rd_sr;
    logic [CW-1:0]  inflight;
    logic [CW-1:0]  fifo_cnt;
    logic           acc;
    logic           rd_acc;
    logic           push;

`ifdef LRAM_REQ_CTRL_SWEEP_EN
    logic [ADDR_W-1:0] swp_addr;
`else
    assign state = RUN;
`endif

    always_comb begin
        inflight = '0;
        for (int i = 0; i < SRW; i++)
            inflight = inflight + CW'(rd_sr[i]);
    end

    // Every in-flight read owns a FIFO slot before it is issued.
    assign req_ready = live && (state == RUN) &&
                       (({1'b0, inflight} + {1'b0, fifo_cnt}) < CAP);
    assign acc    = req_valid && req_ready;
    assign rd_acc = acc && !req_we;
    assign push   = rd_sr[SRW-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            live      <= 1'b0;
            rd_sr     <= '0;
            lram_addr <= '0;
            lram_data <= '0;
            lram_wen  <= 1'b0;
`ifdef LRAM_REQ_CTRL_SWEEP_EN
            state     <= SWEEP;
            swp_addr  <= '0;
`endif
        end else begin
            live     <= 1'b1;
            rd_sr    <= (rd_sr << 1) | SRW'(rd_acc);
            lram_wen <= 1'b0;
            if (acc) begin
                lram_addr <= req_addr;
                lram_wen  <= req_we;
                if (req_we) lram_data <= req_wdata;
            end
`ifdef LRAM_REQ_CTRL_SWEEP_EN
            if (state == SWEEP) begin
                lram_wen  <= 1'b1;
                lram_addr <= swp_addr;
                lram_data <= INIT_VAL;
                swp_addr  <= swp_addr + ADDR_W'(1);
                if (swp_addr == '1) state <= RUN;
            end
`endif
        end
    end

    lram_resp_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .CNT_W  (CW)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (lram_y),
        .pop     (resp_ready),
        .rdata   (resp_rdata),
        .valid   (resp_valid),
        .count   (fifo_cnt)
    );

endmodule

// File: tb/tb_lram_req_ctrl.sv
// Directed self-checking bench for lram_req_ctrl with a 1-cycle LRAM model.
// Sweep checks run when LRAM_REQ_CTRL_SWEEP_EN is defined.
module tb_lram_req_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid, req_ready, req_we;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid, resp_ready;
    logic [7:0] resp_rdata;
    logic [2:0] lram_addr;
    logic [7:0] lram_data;
    logic       lram_wen;
    logic [7:0] lram_y;

    logic [7:0] mem [8];

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;
    int acc_n;
    int waitn;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (lram_wen) mem[lram_addr] <= lram_data;
        lram_y <= mem[lram_addr];
    end

    lram_req_ctrl #(
        .ADDR_W   (3),
        .DATA_W   (8),
        .RD_LAT   (1),
        .DEPTH    (4),
        .INIT_VAL (8'h5A)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .lram_addr  (lram_addr),
        .lram_data  (lram_data),
        .lram_wen   (lram_wen),
        .lram_y     (lram_y)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic we,
                         input logic [2:0] a, input logic [7:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        resp_ready = 1'b0;
        #3;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_lram_addr", lram_addr, 0);
        chk("rst_lram_data", lram_data, 0);
        chk("rst_lram_wen", lram_wen, 0);
        tick;
        reset_n = 1'b1;
        tick;

`ifdef LRAM_REQ_CTRL_SWEEP_EN
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick;
            chk("sweep_wen", lram_wen, 1);
            chk("sweep_addr", lram_addr, c);
            chk("sweep_data", lram_data, 8'h5A);
        end
        drive(1'b1, 1'b0, 3'd5, 8'h00);
        chk("sweep_done_rdy", req_ready, 1);
        tick;
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        tick;
        tick;
        chk("sweep_rd_valid", resp_valid, 1);
        chk("sweep_rd_data", resp_rdata, 8'h5A);
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
`endif

        // write 0x77 to 3, then read 3
        chk("run_rdy", req_ready, 1);
        drive(1'b1, 1'b1, 3'd3, 8'h77);
        tick;
        chk("wr_wen", lram_wen, 1);
        chk("wr_addr", lram_addr, 3);
        chk("wr_data", lram_data, 8'h77);
        drive(1'b1, 1'b0, 3'd3, 8'h00);
        tick;
        chk("rd_wen_low", lram_wen, 0);
        chk("rd_addr", lram_addr, 3);
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        tick;
        chk("rd_lat_not_yet", resp_valid, 0);
        tick;
        chk("rd_lat_valid", resp_valid, 1);
        chk("rd_lat_data", resp_rdata, 8'h77);
        resp_ready = 1'b1;
        tick;
        chk("rd_popped", resp_valid, 0);

        // fill memory with A0+i
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 3'(i), 8'hA0 + 8'(i));
            tick;
        end
        chk("fill_last_addr", lram_addr, 7);
        chk("fill_last_data", lram_data, 8'hA7);

        // back-to-back reads 0..7
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                drive(1'b1, 1'b0, 3'(k), 8'h00);
                chk("b2b_rdy", req_ready, 1);
            end else begin
                drive(1'b0, 1'b0, 3'd0, 8'h00);
            end
            tick;
            if (k >= 2) begin
                chk("b2b_valid", resp_valid, 1);
                chk("b2b_data", resp_rdata, 8'hA0 + 8'(k - 2));
            end
        end
        tick;
        chk("b2b_drained", resp_valid, 0);

        // back-pressure: 6 offers, 4 accepted
        resp_ready = 1'b0;
        acc_n = 0;
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 1'b0, 3'(j), 8'h00);
            if (req_ready) acc_n++;
            tick;
        end
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        chk("bp_accepted", acc_n, 4);
        chk("bp_rdy_low", req_ready, 0);
        resp_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            chk("bp_valid", resp_valid, 1);
            chk("bp_data", resp_rdata, 8'hA0 + 8'(r));
            tick;
        end
        chk("bp_empty", resp_valid, 0);
        chk("bp_rdy_back", req_ready, 1);

        // simultaneous push and pop at 3 entries
        resp_ready = 1'b0;
        for (int j = 4; j < 7; j++) begin
            drive(1'b1, 1'b0, 3'(j), 8'h00);
            tick;
        end
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        tick;
        tick;
        chk("pp_head", resp_rdata, 8'hA4);
        chk("pp_rdy3", req_ready, 1);
        drive(1'b1, 1'b0, 3'd7, 8'h00);
        tick;
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        tick;
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        chk("pp_head_after", resp_rdata, 8'hA5);
        chk("pp_rdy_after", req_ready, 1);
        tick;
        chk("pp_hold", resp_rdata, 8'hA5);
        resp_ready = 1'b1;
        for (int r = 5; r < 8; r++) begin
            chk("pp_valid", resp_valid, 1);
            chk("pp_data", resp_rdata, 8'hA0 + 8'(r));
            tick;
        end
        chk("pp_empty", resp_valid, 0);

        // reset with 2 in flight and 1 queued
        resp_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 1'b0, 3'(j), 8'h00);
            tick;
        end
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        chk("mr_queued", resp_valid, 1);
        chk("mr_queued_data", resp_rdata, 8'hA0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_valid_drop", resp_valid, 0);
        chk("mr_rdata_zero", resp_rdata, 0);
        chk("mr_rdy_low", req_ready, 0);
        tick;
        reset_n = 1'b1;
        resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            chk("mr_no_ghost", resp_valid, 0);
        end
        waitn = 0;
        while (!req_ready && waitn < 20) begin
            tick;
            waitn++;
        end
        chk("mr_rdy_return", req_ready, 1);
        drive(1'b1, 1'b1, 3'd6, 8'hC6);
        tick;
        drive(1'b1, 1'b0, 3'd6, 8'h00);
        tick;
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        tick;
        chk("mr_new_wait", resp_valid, 0);
        tick;
        chk("mr_new_valid", resp_valid, 1);
        chk("mr_new_data", resp_rdata, 8'hC6);
        tick;
        chk("mr_new_popped", resp_valid, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
